rv32im_fetch_seq: RTL and testbench

Sequences the program counter and the instruction-memory fetch handshake for the rv32im core. Holds the architectural fetch PC, issues one fetch at a time, and buffers the returned instruction toward decode. Accepts redirects from the branch unit's br_pc_o output; on a redirect it flushes the buffered instruction and discards any response still in flight.

---
 rtl/rv32im_fetch_seq_pkg.sv | 16 +
 rtl/rv32im_fetch_seq.sv | 128 ++++++++++++
 tb/tb_rv32im_fetch_seq.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_fetch_seq_pkg.sv
// Shared encodings and constants for the rv32im fetch sequencer.
// The FSM encoding is fixed so it can be mirrored in the legacy definitions header.
package rv32im_fetch_seq_pkg;

  typedef enum logic [2:0] {
    FseqBoot  = 3'd0,
    FseqReq   = 3'd1,
    FseqWait  = 3'd2,
    FseqHold  = 3'd3,
    FseqDrain = 3'd4
  } fseq_state_e;

  localparam int unsigned PcIncr         = 4;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/rv32im_fetch_seq.sv
// Fetch PC sequencer: one outstanding instruction fetch, a single-entry buffer toward decode,
// and redirect handling that flushes the buffer and discards in-flight responses.
module rv32im_fetch_seq
  import rv32im_fetch_seq_pkg::*;
#(
  parameter int unsigned               API_ADDR_WIDTH = 32,
  parameter int unsigned               API_DATA_WIDTH = 32,
  parameter logic [API_ADDR_WIDTH-1:0] RESET_PC       = ResetPcDefault,
  parameter int unsigned               DROP_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      redirect_valid_i,
  input  logic [API_ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                      stall_i,
  output logic                      imem_req_valid_o,
  output logic [API_ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                      imem_req_ready_i,
  input  logic                      imem_rsp_valid_i,
  input  logic [API_DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                      if_valid_o,
  output logic [API_ADDR_WIDTH-1:0] if_pc_o,
  output logic [API_DATA_WIDTH-1:0] if_instr_o,
  input  logic                      if_ready_i,
  output logic                      flush_o,
  output logic                      misalign_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  fseq_state_e               state_q, state_d;
  logic [API_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [API_ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [API_ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [API_DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      drop_inc;
  logic [API_ADDR_WIDTH-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = {redirect_pc_i[API_ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= FseqBoot;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    req_pc_d         = req_pc_q;
    if_pc_d          = if_pc_q;
    if_instr_d       = if_instr_q;
    drop_inc         = 1'b0;
    imem_req_valid_o = 1'b0;
    if_valid_o       = 1'b0;

    if (redirect_valid_i) begin
      pc_d = redirect_pc_aligned;
    end

    case (state_q)
      FseqBoot: state_d = FseqReq;
      FseqReq: begin
        imem_req_valid_o = 1'b1;
        if (imem_req_ready_i) begin
          req_pc_d = pc_q;
          // An accepted request still owes a response, so a redirect must drain it.
          state_d  = redirect_valid_i ? FseqDrain : FseqWait;
        end
      end
      FseqWait: begin
        if (imem_rsp_valid_i) begin
          if (redirect_valid_i) begin
            drop_inc = 1'b1;
            state_d  = FseqReq;
          end else begin
            if_instr_d = imem_rsp_data_i;
            if_pc_d    = req_pc_q;
            pc_d       = req_pc_q + API_ADDR_WIDTH'(PcIncr);
            state_d    = FseqHold;
          end
        end else if (redirect_valid_i) begin
          state_d = FseqDrain;
        end
      end
      FseqHold: begin
        if_valid_o = !redirect_valid_i;
        if (redirect_valid_i || (if_ready_i && !stall_i)) begin
          state_d = FseqReq;
        end
      end
      FseqDrain: begin
        if (imem_rsp_valid_i) begin
          drop_inc = 1'b1;
          state_d  = FseqReq;
        end
      end
      default: state_d = FseqBoot;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  assign imem_req_addr_o = pc_q;
  assign if_pc_o         = if_pc_q;
  assign if_instr_o      = if_instr_q;
  assign flush_o         = redirect_valid_i;
  assign misalign_o      = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_rv32im_fetch_seq.sv
// Self-checking bench for rv32im_fetch_seq: memory model with programmable latency,
// scoreboards for accepted fetch addresses and decode handshakes, plus directed redirect cases.
module tb_rv32im_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        mem_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        misalign;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_exp_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  logic [31:0] exp_req_q[$];
  if_exp_t     exp_if_q[$];

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] pend_addr = '0;

  rv32im_fetch_seq dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .stall_i          (stall),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_addr_o  (imem_req_addr),
    .imem_req_ready_i (mem_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr),
    .if_ready_i       (if_ready),
    .flush_o          (flush),
    .misalign_o       (misalign),
    .drop_cnt_o       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory model: response arrives mem_lat edges after the accepting edge.
  always @(posedge clk) begin
    #1;
    rsp_valid = 1'b0;
    if (!rst_n) begin
      mem_cnt = 0;
    end else begin
      if (acc_seen) begin
        mem_cnt   = mem_lat;
        pend_addr = acc_addr;
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_word(pend_addr);
        end
      end
    end
  end

  // Scoreboard side: observe accepted requests and decode handshakes mid-cycle.
  always @(negedge clk) begin
    acc_seen = rst_n && imem_req_valid && mem_ready;
    acc_addr = imem_req_addr;
    if (rst_n) begin
      if (imem_req_valid && mem_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got addr %h expected none", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, exp_req_q.pop_front());
        end
      end
      if (if_valid && if_ready && !stall) begin
        if (exp_if_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if_unexpected: got pc %h expected none", if_pc);
        end else begin
          if_exp_t e;
          e = exp_if_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue();
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("issue_timeout", {31'b0, imem_req_valid}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic consume();
    int n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    chk("consume_timeout", {31'b0, if_valid}, 32'd1);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    if_exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    exp_req_q.push_back(a);
    exp_if_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   issue_cyc[$];
    int   n;

    vecs[0] = '{tgt: 32'h0000_0302, exp_addr: 32'h0000_0300, exp_mis: 1'b1};
    vecs[1] = '{tgt: 32'h0000_0040, exp_addr: 32'h0000_0040, exp_mis: 1'b0};
    vecs[2] = '{tgt: 32'h8000_0001, exp_addr: 32'h8000_0000, exp_mis: 1'b1};
    vecs[3] = '{tgt: 32'h0000_0ABE, exp_addr: 32'h0000_0ABC, exp_mis: 1'b1};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    mem_ready = 1'b0; if_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);

    // Streaming fetch: issues at cycles 1, 4, 7 after release
    push_fetch(32'h0);
    push_fetch(32'h4);
    push_fetch(32'h8);
    rst_n = 1'b1; mem_ready = 1'b1; if_ready = 1'b1;
    chk("boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (imem_req_valid && mem_ready) issue_cyc.push_back(i);
      if (i == 9) mem_ready = 1'b0;
      if (i == 10) if_ready = 1'b0;
    end
    chk("stream_issue_count", issue_cyc.size(), 32'd3);
    if (issue_cyc.size() == 3) begin
      chk("stream_issue0", issue_cyc[0], 32'd1);
      chk("stream_issue1", issue_cyc[1], 32'd4);
      chk("stream_issue2", issue_cyc[2], 32'd7);
    end

    // Back-pressure in REQ holds address and valid
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("bp_req_addr", imem_req_addr, 32'h0000_000C);
      tick();
    end
    push_fetch(32'h0000_000C);
    issue();
    consume();

    // Redirect in WAIT, response 3 cycles later is discarded
    mem_lat = 3;
    exp_req_q.push_back(32'h0000_0010);
    issue();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    chk("wait_redir_flush", {31'b0, flush}, 32'd1);
    chk("wait_redir_mis", {31'b0, misalign}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("drain_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("drain_drop_before", {24'b0, drop_cnt}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("drain_rsp_seen", {31'b0, rsp_valid}, 32'd1);
    tick();
    chk("drain_drop_after", {24'b0, drop_cnt}, 32'd1);
    chk("drain_next_addr", imem_req_addr, 32'h0000_0100);
    push_fetch(32'h0000_0100);
    issue();
    consume();

    // Redirect in HOLD under stall: buffer dropped, no handshake
    mem_lat = 1;
    exp_req_q.push_back(32'h0000_0104);
    issue();
    n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    stall = 1'b1; if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("hold_redir_flush", {31'b0, flush}, 32'd1);
    chk("hold_redir_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; stall = 1'b0; if_ready = 1'b0;
    chk("hold_after_if_valid", {31'b0, if_valid}, 32'd0);
    chk("hold_drop_same", {24'b0, drop_cnt}, 32'd1);
    push_fetch(32'h0000_0200);
    issue();
    consume();

    // Table: redirect target alignment and misalign pulse
    for (int i = 0; i < 4; i++) begin
      redirect_valid = 1'b1; redirect_pc = vecs[i].tgt;
      #1;
      chk("tbl_flush", {31'b0, flush}, 32'd1);
      chk("tbl_misalign", {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      tick();
      redirect_valid = 1'b0;
      chk("tbl_flush_off", {31'b0, flush}, 32'd0);
      push_fetch(vecs[i].exp_addr);
      issue();
      consume();
    end

    // Redirect coincident with response, repeated: counter saturates
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      exp_req_q.push_back(32'hFFFF_FFFC);
      issue();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      if (i == 100) chk("sat_drop_100", {24'b0, drop_cnt}, 32'd101);
      if (i == 254) chk("sat_drop_254", {24'b0, drop_cnt}, 32'd255);
    end
    chk("sat_drop_end", {24'b0, drop_cnt}, 32'd255);

    // PC wrap from the top of the address space
    push_fetch(32'hFFFF_FFFC);
    issue();
    consume();
    chk("wrap_addr", imem_req_addr, 32'h0);
    push_fetch(32'h0);
    issue();
    consume();

    // Reset mid-transaction returns to the boot state
    mem_lat = 3;
    exp_req_q.push_back(32'h4);
    issue();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mid_rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_addr", imem_req_addr, 32'd0);
    tick();

    chk("sb_req_empty", exp_req_q.size(), 32'd0);
    chk("sb_if_empty", exp_if_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
